// File: rtl/controller_sequencer_if.sv
// Control bus between the SAP-1 controller-sequencer and its datapath.
// The instruction register supplies the opcode. The sequencer drives every
// control strobe, the halt flag and the one-hot T-state.
// master: the sequencer side. slave: the datapath side.
interface controller_sequencer_if #(
  parameter int OPCODE_WIDTH = 4
);
  logic [OPCODE_WIDTH-1:0] opcode;
  logic                    Cp;
  logic                    Ep;
  logic                    Lm_bar;
  logic                    CE_bar;
  logic                    Li_bar;
  logic                    Ei_bar;
  logic                    La_bar;
  logic                    Ea;
  logic                    Su;
  logic                    Eu;
  logic                    Lb_bar;
  logic                    Lo_bar;
  logic                    halt;
  logic [5:0]              t_state;

  modport master (
    input  opcode,
    output Cp, Ep, Lm_bar, CE_bar, Li_bar, Ei_bar, La_bar,
           Ea, Su, Eu, Lb_bar, Lo_bar, halt, t_state
  );

  modport slave (
    output opcode,
    input  Cp, Ep, Lm_bar, CE_bar, Li_bar, Ei_bar, La_bar,
           Ea, Su, Eu, Lb_bar, Lo_bar, halt, t_state
  );
endinterface

// File: rtl/controller_sequencer.sv
// SAP-1 controller-sequencer.
// A six-state one-hot ring counter (T1..T6) is decoded together with the IR
// opcode into the 12-signal control word for the datapath.
// Optional build macro CTRL_SKIP_NOP_EN: when it is defined, the ring returns
// to T1 right after an instruction's last useful state instead of padding
// the instruction out with no-op states.
module controller_sequencer #(
  parameter int                    OPCODE_WIDTH = 4,
  parameter logic [OPCODE_WIDTH-1:0] OP_LDA     = 4'b0000,
  parameter logic [OPCODE_WIDTH-1:0] OP_ADD     = 4'b0001,
  parameter logic [OPCODE_WIDTH-1:0] OP_SUB     = 4'b0010,
  parameter logic [OPCODE_WIDTH-1:0] OP_OUT     = 4'b1110,
  parameter logic [OPCODE_WIDTH-1:0] OP_HLT     = 4'b1111
) (
  input  logic                   clk,
  input  logic                   clear,
  controller_sequencer_if.master bus
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

  t_state_e state_q, state_d;
  logic     halt_q, halt_d;

  logic cp_c, ep_c, lm_bar_c, ce_bar_c, li_bar_c, ei_bar_c;
  logic la_bar_c, ea_c, su_c, eu_c, lb_bar_c, lo_bar_c;

  // Register the ring position and the halt flag; clear overrides both at once.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= T1;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
    end
  end

  // Advance the ring. HLT parks it in T4, and only clear can leave that state.
  always_comb begin
    state_d = state_q;
    halt_d  = halt_q;
    if (!halt_q) begin
      case (state_q)
        T1: state_d = T2;
        T2: state_d = T3;
        T3: state_d = T4;
        T4: begin
          if (bus.opcode == OP_HLT) begin
            state_d = T4;
            halt_d  = 1'b1;
          end
`ifdef CTRL_SKIP_NOP_EN
          else if (bus.opcode == OP_LDA || bus.opcode == OP_ADD ||
                   bus.opcode == OP_SUB) begin
            state_d = T5;
          end else begin
            state_d = T1;
          end
`else
          else begin
            state_d = T5;
          end
`endif
        end
        T5: begin
`ifdef CTRL_SKIP_NOP_EN
          if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) state_d = T6;
          else                                              state_d = T1;
`else
          state_d = T6;
`endif
        end
        T6:      state_d = T1;
        default: state_d = T1;
      endcase
    end
  end

  // Decode the control word. Every strobe is held inactive while clear is
  // high or the machine is halted.
  always_comb begin
    cp_c     = 1'b0;
    ep_c     = 1'b0;
    lm_bar_c = 1'b1;
    ce_bar_c = 1'b1;
    li_bar_c = 1'b1;
    ei_bar_c = 1'b1;
    la_bar_c = 1'b1;
    ea_c     = 1'b0;
    su_c     = 1'b0;
    eu_c     = 1'b0;
    lb_bar_c = 1'b1;
    lo_bar_c = 1'b1;
    if (!clear && !halt_q) begin
      case (state_q)
        T1: begin
          ep_c     = 1'b1;
          lm_bar_c = 1'b0;
        end
        T2: cp_c = 1'b1;
        T3: begin
          ce_bar_c = 1'b0;
          li_bar_c = 1'b0;
        end
        T4: begin
          if (bus.opcode == OP_LDA || bus.opcode == OP_ADD ||
              bus.opcode == OP_SUB) begin
            ei_bar_c = 1'b0;
            lm_bar_c = 1'b0;
          end else if (bus.opcode == OP_OUT) begin
            ea_c     = 1'b1;
            lo_bar_c = 1'b0;
          end
        end
        T5: begin
          if (bus.opcode == OP_LDA) begin
            ce_bar_c = 1'b0;
            la_bar_c = 1'b0;
          end else if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
            ce_bar_c = 1'b0;
            lb_bar_c = 1'b0;
            su_c     = (bus.opcode == OP_SUB);
          end
        end
        T6: begin
          if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
            eu_c     = 1'b1;
            la_bar_c = 1'b0;
            su_c     = (bus.opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Cp      = cp_c;
  assign bus.Ep      = ep_c;
  assign bus.Lm_bar  = lm_bar_c;
  assign bus.CE_bar  = ce_bar_c;
  assign bus.Li_bar  = li_bar_c;
  assign bus.Ei_bar  = ei_bar_c;
  assign bus.La_bar  = la_bar_c;
  assign bus.Ea      = ea_c;
  assign bus.Su      = su_c;
  assign bus.Eu      = eu_c;
  assign bus.Lb_bar  = lb_bar_c;
  assign bus.Lo_bar  = lo_bar_c;
  assign bus.halt    = halt_q;
  assign bus.t_state = state_q;

endmodule

// File: tb/tb_controller_sequencer.sv
// Directed testbench for controller_sequencer.
// Each expected control word below is written by hand in this bit order:
// {Cp, Ep, Lm_bar, CE_bar, Li_bar, Ei_bar, La_bar, Ea, Su, Eu, Lb_bar, Lo_bar}
module tb_controller_sequencer;

  localparam logic [5:0] S1 = 6'b000001;
  localparam logic [5:0] S2 = 6'b000010;
  localparam logic [5:0] S3 = 6'b000100;
  localparam logic [5:0] S4 = 6'b001000;
  localparam logic [5:0] S5 = 6'b010000;
  localparam logic [5:0] S6 = 6'b100000;

  localparam logic [11:0] W_IDLE   = 12'b001111100011;
  localparam logic [11:0] W_T1     = 12'b010111100011;
  localparam logic [11:0] W_T2     = 12'b101111100011;
  localparam logic [11:0] W_T3     = 12'b001001100011;
  localparam logic [11:0] W_ADR    = 12'b000110100011;
  localparam logic [11:0] W_LDA5   = 12'b001011000011;
  localparam logic [11:0] W_ADD5   = 12'b001011100001;
  localparam logic [11:0] W_ADD6   = 12'b001111000111;
  localparam logic [11:0] W_SUB5   = 12'b001011101001;
  localparam logic [11:0] W_SUB6   = 12'b001111001111;
  localparam logic [11:0] W_OUT4   = 12'b001111110010;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_UND = 4'b0101;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  logic clk;
  logic clear;
  int   checks;
  int   errors;

  controller_sequencer_if #(.OPCODE_WIDTH(4)) bus ();

  controller_sequencer dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus.master)
  );

  logic [11:0] ctrl_word;
  assign ctrl_word = {bus.Cp, bus.Ep, bus.Lm_bar, bus.CE_bar, bus.Li_bar,
                      bus.Ei_bar, bus.La_bar, bus.Ea, bus.Su, bus.Eu,
                      bus.Lb_bar, bus.Lo_bar};

  // Free-running clock with its rising edge at 5, 15, 25, and so on.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Set the opcode, then move one rising edge forward and settle 1 time unit.
  task automatic applyStimulus(input logic [3:0] op);
    bus.opcode = op;
    @(posedge clk);
    #1;
  endtask

  // Compare state, control word and halt, and confirm that at most one bus
  // driver is enabled.
  task automatic checkOutput(input string tag, input logic [5:0] exp_t,
                             input logic [11:0] exp_w, input logic exp_h);
    int enables;
    checks++;
    assert (bus.t_state === exp_t) else begin
      errors++;
      $error("FAIL %s t_state got %b want %b", tag, bus.t_state, exp_t);
    end
    checks++;
    assert (ctrl_word === exp_w) else begin
      errors++;
      $error("FAIL %s ctrl got %b want %b", tag, ctrl_word, exp_w);
    end
    checks++;
    assert (bus.halt === exp_h) else begin
      errors++;
      $error("FAIL %s halt got %b want %b", tag, bus.halt, exp_h);
    end
    enables = int'(bus.Ep) + int'(bus.Ea) + int'(bus.Eu) +
              int'(!bus.CE_bar) + int'(!bus.Ei_bar);
    checks++;
    assert (enables <= 1) else begin
      errors++;
      $error("FAIL %s bus_enables got %0d want <=1", tag, enables);
    end
  endtask

  // Directed sequence: reset, LDA, SUB, ADD with a clear pulse, an undefined
  // opcode, OUT, HLT, and finally leaving halt through clear.
  initial begin
    checks     = 0;
    errors     = 0;
    clear      = 1'b1;
    bus.opcode = OP_LDA;
    $display("[TB] controller_sequencer directed test start");

    // Hold clear over three edges.
    applyStimulus(OP_LDA);
    applyStimulus(OP_LDA);
    applyStimulus(OP_LDA);
    checkOutput("reset", S1, W_IDLE, 1'b0);
    clear = 1'b0;
    #1;
    checkOutput("lda_t1", S1, W_T1, 1'b0);

    // LDA
    applyStimulus(OP_LDA); checkOutput("lda_t2", S2, W_T2, 1'b0);
    applyStimulus(OP_LDA); checkOutput("lda_t3", S3, W_T3, 1'b0);
    applyStimulus(OP_LDA); checkOutput("lda_t4", S4, W_ADR, 1'b0);
    applyStimulus(OP_LDA); checkOutput("lda_t5", S5, W_LDA5, 1'b0);
`ifndef CTRL_SKIP_NOP_EN
    applyStimulus(OP_LDA); checkOutput("lda_t6", S6, W_IDLE, 1'b0);
`endif
    applyStimulus(OP_SUB); checkOutput("sub_t1", S1, W_T1, 1'b0);

    // SUB
    applyStimulus(OP_SUB); checkOutput("sub_t2", S2, W_T2, 1'b0);
    applyStimulus(OP_SUB); checkOutput("sub_t3", S3, W_T3, 1'b0);
    applyStimulus(OP_SUB); checkOutput("sub_t4", S4, W_ADR, 1'b0);
    applyStimulus(OP_SUB); checkOutput("sub_t5", S5, W_SUB5, 1'b0);
    applyStimulus(OP_SUB); checkOutput("sub_t6", S6, W_SUB6, 1'b0);
    applyStimulus(OP_ADD); checkOutput("add_t1", S1, W_T1, 1'b0);

    // ADD, first a complete pass and then a pass interrupted by clear in T5
    applyStimulus(OP_ADD); checkOutput("add_t2", S2, W_T2, 1'b0);
    applyStimulus(OP_ADD); checkOutput("add_t3", S3, W_T3, 1'b0);
    applyStimulus(OP_ADD); checkOutput("add_t4", S4, W_ADR, 1'b0);
    applyStimulus(OP_ADD); checkOutput("add_t5", S5, W_ADD5, 1'b0);
    applyStimulus(OP_ADD); checkOutput("add_t6", S6, W_ADD6, 1'b0);
    applyStimulus(OP_ADD); checkOutput("add2_t1", S1, W_T1, 1'b0);
    applyStimulus(OP_ADD); checkOutput("add2_t2", S2, W_T2, 1'b0);
    applyStimulus(OP_ADD); checkOutput("add2_t3", S3, W_T3, 1'b0);
    applyStimulus(OP_ADD); checkOutput("add2_t4", S4, W_ADR, 1'b0);
    applyStimulus(OP_ADD); checkOutput("add2_t5", S5, W_ADD5, 1'b0);
    #1 clear = 1'b1;
    #1 checkOutput("clr_async", S1, W_IDLE, 1'b0);
    applyStimulus(OP_UND); checkOutput("clr_held", S1, W_IDLE, 1'b0);
    clear = 1'b0;
    #1 checkOutput("clr_rel_t1", S1, W_T1, 1'b0);

    // Undefined opcode 0101: T4..T6 perform no operation
    applyStimulus(OP_UND); checkOutput("und_t2", S2, W_T2, 1'b0);
    applyStimulus(OP_UND); checkOutput("und_t3", S3, W_T3, 1'b0);
    applyStimulus(OP_UND); checkOutput("und_t4", S4, W_IDLE, 1'b0);
`ifndef CTRL_SKIP_NOP_EN
    applyStimulus(OP_UND); checkOutput("und_t5", S5, W_IDLE, 1'b0);
    applyStimulus(OP_UND); checkOutput("und_t6", S6, W_IDLE, 1'b0);
`endif
    applyStimulus(OP_OUT); checkOutput("out_t1", S1, W_T1, 1'b0);

    // OUT
    applyStimulus(OP_OUT); checkOutput("out_t2", S2, W_T2, 1'b0);
    applyStimulus(OP_OUT); checkOutput("out_t3", S3, W_T3, 1'b0);
    applyStimulus(OP_OUT); checkOutput("out_t4", S4, W_OUT4, 1'b0);
`ifndef CTRL_SKIP_NOP_EN
    applyStimulus(OP_OUT); checkOutput("out_t5", S5, W_IDLE, 1'b0);
    applyStimulus(OP_OUT); checkOutput("out_t6", S6, W_IDLE, 1'b0);
`endif
    applyStimulus(OP_HLT); checkOutput("hlt_t1", S1, W_T1, 1'b0);

    // HLT, which parks the ring in T4 with every control inactive
    applyStimulus(OP_HLT); checkOutput("hlt_t2", S2, W_T2, 1'b0);
    applyStimulus(OP_HLT); checkOutput("hlt_t3", S3, W_T3, 1'b0);
    applyStimulus(OP_HLT); checkOutput("hlt_t4", S4, W_IDLE, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(OP_HLT);
      checkOutput("halted", S4, W_IDLE, 1'b1);
    end

    // Only clear leaves the halted state
    #1 clear = 1'b1;
    #1 checkOutput("hlt_clr", S1, W_IDLE, 1'b0);
    applyStimulus(OP_LDA);
    clear = 1'b0;
    #1 checkOutput("post_t1", S1, W_T1, 1'b0);
    applyStimulus(OP_LDA); checkOutput("post_t2", S2, W_T2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
